// File: rtl/led_fade_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_driver_pkg
// Description : Shared widths and FSM state type for the LED fade driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_fade_driver_pkg;

    localparam int BITS      = 4;
    localparam int PWM_BITS  = 8;
    localparam int FADE_LOG2 = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_channel
// Description : One LED channel: level/target registers, unit step, PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_channel
    import led_fade_driver_pkg::*;
#(
    parameter int PWM_BITS = led_fade_driver_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_new_on,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic                i_step,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led,
    output logic                o_at_target,
    output logic                o_new_match
);

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS-1:0] w_level_next;
    logic [PWM_BITS-1:0] w_new_target;
    logic                r_led;

    assign w_new_target = i_new_on ? i_brightness : '0;

    always_comb begin
        w_level_next = r_level;
        if (i_step) begin
            if (r_level < r_target) begin
                w_level_next = r_level + PWM_BITS'(1);
            end else if (r_level > r_target) begin
                w_level_next = r_level - PWM_BITS'(1);
            end
        end
    end

    // Looks past the current step so the FSM can leave FADE on the final step edge.
    assign o_at_target = (w_level_next == r_target);
    assign o_new_match = (r_level == w_new_target);
    assign o_led       = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level  <= '0;
            r_target <= '0;
            r_led    <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_led   <= (r_level > i_pwm_cnt);
            if (i_load) begin
                r_target <= w_new_target;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_fade_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_driver
// Description : PWM LED driver fading each channel toward its on/off target.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_driver
    import led_fade_driver_pkg::*;
#(
    parameter int BITS      = led_fade_driver_pkg::BITS,
    parameter int PWM_BITS  = led_fade_driver_pkg::PWM_BITS,
    parameter int FADE_LOG2 = led_fade_driver_pkg::FADE_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BITS-1:0]     in_data,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                in_ready,
    output logic [BITS-1:0]     led,
    output logic                busy
);

    fade_state_t         r_state;
    fade_state_t         w_state_next;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_pwm_max;
    logic                w_strobe;
    logic                w_xfer;
    logic                w_step;
    logic [BITS-1:0]     w_at_target;
    logic [BITS-1:0]     w_new_match;

    assign w_pwm_max = &r_pwm_cnt;
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == FADE);
    assign w_xfer    = in_valid && in_ready;
    assign w_step    = w_strobe && busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    generate
        if (FADE_LOG2 > 0) begin : g_fade_cnt
            logic [FADE_LOG2-1:0] r_fade_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_fade_cnt <= '0;
                end else if (w_pwm_max) begin
                    r_fade_cnt <= r_fade_cnt + FADE_LOG2'(1);
                end
            end

            assign w_strobe = w_pwm_max && (&r_fade_cnt);
        end else begin : g_no_fade_cnt
            assign w_strobe = w_pwm_max;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < BITS; gi++) begin : g_chan
            led_fade_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .i_load       (w_xfer),
                .i_new_on     (in_data[gi]),
                .i_brightness (brightness),
                .i_step       (w_step),
                .i_pwm_cnt    (r_pwm_cnt),
                .o_led        (led[gi]),
                .o_at_target  (w_at_target[gi]),
                .o_new_match  (w_new_match[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && !(&w_new_match)) begin
                    w_state_next = FADE;
                end
            end
            FADE: begin
                if (&w_at_target) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

endmodule
`default_nettype wire
